// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with a registered Result/ZERO and optional
// iterative MUL/DIVU/REMU, compiled in when ALU_SEQ_MULDIV_EN is defined.
module alu_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             ZERO,
    output logic             busy
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;

    // Single-step operations; unknown opcodes yield zero.
    function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        case (op)
            OP_AND:  single_op = x & y;
            OP_OR:   single_op = x | y;
            OP_ADD:  single_op = x + y;
            OP_SUB:  single_op = x - y;
            OP_NOR:  single_op = ~(x | y);
            default: single_op = '0;
        endcase
    endfunction

`ifdef ALU_SEQ_MULDIV_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0101;

    // acc: product / partial remainder; opa: multiplier / quotient; opb: multiplicand / divisor
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic [WIDTH-1:0] mul_acc, div_rem, div_quo;
    logic             is_multi;

    assign is_multi = (ALUOp == OP_MUL) || (ALUOp == OP_DIVU) || (ALUOp == OP_REMU);

    // One shift-add step and one restoring-division step from the current registers.
    always_comb begin
        mul_acc = opa_q[0] ? (acc_q + opb_q) : acc_q;
        rem_sh  = {acc_q, opa_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, opb_q};
        if (!rem_sub[WIDTH]) begin
            div_rem = rem_sub[WIDTH-1:0];
            div_quo = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem = rem_sh[WIDTH-1:0];
            div_quo = {opa_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        result_d = Result;
        zero_d   = ZERO;
`ifdef ALU_SEQ_MULDIV_EN
        cnt_d = cnt_q;
        op_d  = op_q;
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (is_multi) begin
                        state_d = BUSY;
                        op_d    = ALUOp;
                        cnt_d   = '0;
                        acc_d   = '0;
                        opa_d   = a;
                        opb_d   = b;
                    end else
`endif
                    begin
                        state_d  = DONE;
                        result_d = single_op(ALUOp, a, b);
                        zero_d   = (result_d == '0);
                    end
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    opa_d = opa_q >> 1;
                    opb_d = opb_q << 1;
                end else begin
                    acc_d = div_rem;
                    opa_d = div_quo;
                end
                // Last iteration: counter reaches WIDTH and never wraps.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    if (op_q == OP_MUL)       result_d = mul_acc;
                    else if (op_q == OP_DIVU) result_d = div_quo;
                    else                      result_d = div_rem;
                    zero_d = (result_d == '0);
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            Result    <= '0;
            ZERO      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            Result    <= result_d;
            ZERO      <= zero_d;
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
            in_ready  <= (state_d == IDLE);
        end
    end

`ifdef ALU_SEQ_MULDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= '0;
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
        end
    end
`endif

endmodule
